// File: rtl/accel_sample_filter.sv
// Moving-average filter over 2^TAPS_LOG2 signed samples, triggered by sample-tick rising edges.
// Latency: rise sampled in cycle T, filt_out/filt_valid visible in T+3; readdata is combinational.
// Backpressure: none; a rise while busy is dropped and recorded as overrun (sticky flag + counter).
module accel_sample_filter #(
  parameter int DATA_W    = 16,
  parameter int TAPS_LOG2 = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] sample_in,
  output logic [DATA_W-1:0] filt_out,
  output logic              filt_valid,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata
);

  localparam int N     = 1 << TAPS_LOG2;
  localparam int ACC_W = DATA_W + TAPS_LOG2;
  localparam int CNT_W = TAPS_LOG2 + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_OUTPUT
  } state_t;

  state_t state, state_nxt;

  logic              tick_d;
  logic              armed;      // low for the first cycle after reset so a held tick is not a rise
  logic              rise;
  logic              clear;
  logic [DATA_W-1:0] s_reg;
  logic [DATA_W-1:0] line [N];
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic              overrun;
  logic [15:0]       ovr_cnt;
  logic              primed;
  logic [7:0]        count8;
  logic [ACC_W-1:0]  s_ext;
  logic [ACC_W-1:0]  old_ext;
  logic              wr_unused;

  assign rise    = sample_tick & ~tick_d & armed;
  assign clear   = chipselect & ~write_n & (address == 2'd3) & writedata[0];
  assign primed  = (count == CNT_W'(N));
  assign count8  = {{(8-CNT_W){1'b0}}, count};
  assign s_ext   = {{TAPS_LOG2{s_reg[DATA_W-1]}}, s_reg};
  assign old_ext = {{TAPS_LOG2{line[N-1][DATA_W-1]}}, line[N-1]};
  assign wr_unused = &{1'b0, writedata[31:1]};

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state; a clear always returns to idle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (rise) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_OUTPUT;
      S_OUTPUT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (clear) state_nxt = S_IDLE;
  end

  // Datapath: capture, running sum update, output register and overrun tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_d     <= 1'b0;
      armed      <= 1'b0;
      filt_valid <= 1'b0;
      filt_out   <= '0;
      s_reg      <= '0;
      acc        <= '0;
      count      <= '0;
      overrun    <= 1'b0;
      ovr_cnt    <= '0;
      for (int i = 0; i < N; i++) line[i] <= '0;
    end else begin
      tick_d     <= sample_tick;
      armed      <= 1'b1;
      filt_valid <= 1'b0;
      if (clear) begin
        filt_out <= '0;
        s_reg    <= '0;
        acc      <= '0;
        count    <= '0;
        overrun  <= 1'b0;
        ovr_cnt  <= '0;
        for (int i = 0; i < N; i++) line[i] <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (rise) s_reg <= sample_in;
          end
          S_UPDATE: begin
            acc     <= acc + s_ext - old_ext;
            line[0] <= s_reg;
            for (int i = 1; i < N; i++) line[i] <= line[i-1];
            if (!primed) count <= count + 1'b1;
          end
          S_OUTPUT: begin
            filt_out   <= acc[ACC_W-1:TAPS_LOG2];
            filt_valid <= 1'b1;
          end
          default: ;
        endcase
        if (rise && (state != S_IDLE)) begin
          overrun <= 1'b1;
          if (ovr_cnt != 16'hFFFF) ovr_cnt <= ovr_cnt + 16'd1;
        end
      end
    end
  end

  // Register readback; status packs {ovr_cnt, count, 6'b0, overrun, primed} into 32 bits
  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: readdata = {{(32-DATA_W){filt_out[DATA_W-1]}}, filt_out};
      2'd1: readdata = {{(32-DATA_W){s_reg[DATA_W-1]}}, s_reg};
      2'd2: readdata = {ovr_cnt, count8, 6'b0, overrun, primed};
      default: readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_accel_sample_filter.sv
// Scoreboard bench for accel_sample_filter: a reference average model pushes expected outputs.
// Each expected result carries the cycle it must appear in (rise cycle + 3).
// A negedge monitor pops and compares on every filt_valid pulse.
module tb_accel_sample_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic [15:0] sample_in;
  logic [15:0] filt_out;
  logic        filt_valid;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  accel_sample_filter #(.DATA_W(16), .TAPS_LOG2(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_tick(sample_tick),
    .sample_in  (sample_in),
    .filt_out   (filt_out),
    .filt_valid (filt_valid),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t popped;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  // reference model state
  int   mline[8];
  int   mcount;
  int   movr;
  int   mocnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mline[i] = 0;
    mcount = 0;
    movr   = 0;
    mocnt  = 0;
  endtask

  // accepted sample: shift model line, average by floor division, queue result
  task automatic model_push(input logic [15:0] s);
    int   sum;
    int   avg;
    exp_t e;
    for (int i = 7; i > 0; i--) mline[i] = mline[i-1];
    mline[0] = int'($signed(s));
    sum = 0;
    for (int i = 0; i < 8; i++) sum += mline[i];
    avg = sum >>> 3;
    if (mcount < 8) mcount++;
    e.val = avg[15:0];
    e.due = cyc + 3;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] status_exp();
    logic [15:0] oc;
    logic [7:0]  cn;
    oc = mocnt[15:0];
    cn = mcount[7:0];
    return {oc, cn, 6'b0, movr[0], (mcount == 8)};
  endfunction

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address    = a;
    chipselect = 1'b1;
    #2;
    chk(tag, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic do_clear();
    wr(2'd3, 32'd1);
    model_clear();
  endtask

  task automatic do_tick(input logic [15:0] s, input int hold, input int gap);
    sample_in   = s;
    sample_tick = 1'b1;
    model_push(s);
    step(hold);
    sample_tick = 1'b0;
    step(gap);
  endtask

  // output monitor: every pulse must match the head of the scoreboard in value and cycle
  always @(negedge clk) begin
    if (filt_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        popped = sb.pop_front();
        chk("filt_out", {16'd0, filt_out}, {16'd0, popped.val});
        chk("latency", cyc, popped.due);
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      chk("missing_valid", 32'd0, 32'd1);
      popped = sb.pop_front();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    reset       = 1'b1;
    sample_tick = 1'b1;
    sample_in   = 16'h5555;
    address     = 2'd0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = 32'd0;

    // reset with tick held high
    step(2);
    chk("rst_valid", {31'd0, filt_valid}, 32'd0);
    rd(2'd0, 32'd0, "rst_addr0");
    rd(2'd1, 32'd0, "rst_addr1");
    rd(2'd2, 32'd0, "rst_addr2");
    rd(2'd3, 32'd0, "rst_addr3");
    reset = 1'b0;
    step(4);
    rd(2'd1, 32'd0, "held_after_rst_sreg");
    rd(2'd2, 32'd0, "held_after_rst_status");
    sample_tick = 1'b0;
    step(3);

    // step fill
    for (int i = 0; i < 8; i++) do_tick(16'h0100, 1, 9);
    rd(2'd2, status_exp(), "fill_status");
    chk("fill_primed_count", status_exp(), 32'h0000_0801);
    rd(2'd0, 32'h0000_0100, "fill_addr0");
    rd(2'd1, 32'h0000_0100, "fill_addr1");

    // ignored writes: wrong address, or clear bit low
    wr(2'd0, 32'd1);
    wr(2'd3, 32'd2);
    rd(2'd2, 32'h0000_0801, "ignored_write_status");

    // eviction
    do_tick(16'h0000, 1, 9);

    // negative after clear
    do_clear();
    rd(2'd2, 32'd0, "clear_status");
    rd(2'd0, 32'd0, "clear_addr0");
    do_tick(16'hFFFF, 1, 9);
    rd(2'd0, 32'hFFFF_FFFF, "neg_addr0");
    rd(2'd1, 32'hFFFF_FFFF, "neg_addr1");

    // extremes, minimum 3-cycle tick period
    do_clear();
    for (int i = 0; i < 8; i++) do_tick(16'h7FFF, 1, 2);
    for (int i = 0; i < 8; i++) do_tick(16'h8000, 1, 2);
    step(5);
    rd(2'd0, 32'hFFFF_8000, "extreme_addr0");
    rd(2'd2, status_exp(), "extreme_status");

    // overrun: rise at T, low at T+1, high again at T+2
    do_clear();
    sample_in   = 16'h0040;
    sample_tick = 1'b1;
    model_push(16'h0040);
    step(1);
    sample_tick = 1'b0;
    step(1);
    sample_in   = 16'h1234;
    sample_tick = 1'b1;
    movr  = 1;
    mocnt = mocnt + 1;
    step(1);
    sample_tick = 1'b0;
    step(8);
    rd(2'd2, status_exp(), "ovr_status");
    chk("ovr_status_model", status_exp(), 32'h0001_0102);
    rd(2'd1, 32'h0000_0040, "ovr_sreg_kept");

    // held-high tick: single sample, no overrun
    do_tick(16'h0080, 20, 10);
    rd(2'd2, 32'h0001_0202, "held_status");

    // clear coincident with a rise
    address     = 2'd3;
    writedata   = 32'd1;
    chipselect  = 1'b1;
    write_n     = 1'b0;
    sample_in   = 16'h0100;
    sample_tick = 1'b1;
    step(1);
    chipselect  = 1'b0;
    write_n     = 1'b1;
    model_clear();
    step(2);
    sample_tick = 1'b0;
    step(6);
    rd(2'd2, 32'd0, "clr_rise_status");
    rd(2'd1, 32'd0, "clr_rise_sreg");

    // clear while in UPDATE aborts the sample
    sample_in   = 16'h0300;
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    do_clear();
    step(6);
    rd(2'd2, 32'd0, "clr_upd_status");
    rd(2'd0, 32'd0, "clr_upd_addr0");
    do_tick(16'h0100, 1, 9);
    rd(2'd0, 32'h0000_0020, "after_clr_addr0");
    rd(2'd2, 32'h0000_0100, "after_clr_status");

    step(10);
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
